// File: rtl/seq_detect_pkg.sv
// Shared constants and config typedef for the programmable serial pattern detector.
// Optional build macro SEQ_DET_MASK_EN adds a per-bit compare mask to the config bundle.
package seq_detect_pkg;

  localparam int         DEF_MAX_LEN = 8;
  localparam logic [7:0] DEF_RST_PAT = 8'b0000_0110;
  localparam int         DEF_RST_LEN = 4;
  localparam bit         DEF_RST_OVL = 1'b1;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Config bundle at the default pattern width, for consumers outside the detector.
  typedef struct packed {
    logic [DEF_MAX_LEN-1:0]          pat;
    logic [$clog2(DEF_MAX_LEN+1)-1:0] len;
    logic                            ovl;
`ifdef SEQ_DET_MASK_EN
    logic [DEF_MAX_LEN-1:0]          mask;
`endif
  } seq_cfg_t;

endpackage

// File: rtl/seq_window_cmp.sv
// Combinational compare of the low len bits of the shift window against the pattern.
// With SEQ_DET_MASK_EN defined, mask bits of 0 are don't-care.
module seq_window_cmp #(
  parameter int MAX_LEN = 8,
  parameter int LW      = 4
) (
  input  logic [MAX_LEN-1:0] win_i,
  input  logic [MAX_LEN-1:0] pat_i,
  input  logic [LW-1:0]      len_i,
`ifdef SEQ_DET_MASK_EN
  input  logic [MAX_LEN-1:0] mask_i,
`endif
  output logic               hit_o
);

  logic [MAX_LEN-1:0] diff;

  always_comb begin
    diff = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len_i)) begin
`ifdef SEQ_DET_MASK_EN
        diff[i] = (win_i[i] ^ pat_i[i]) & mask_i[i];
`else
        diff[i] = win_i[i] ^ pat_i[i];
`endif
      end
    end
  end

  assign hit_o = (diff == '0);

endmodule

// File: rtl/param_seq_detect.sv
// Runtime-programmable serial bit-pattern detector with one-cycle match flag and
// saturating match counter. SEQ_DET_MASK_EN adds the cfg_mask don't-care port.
module param_seq_detect
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN = DEF_MAX_LEN,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(DEF_RST_PAT),
  parameter int                 RST_LEN = DEF_RST_LEN,
  parameter bit                 RST_OVL = DEF_RST_OVL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din,
  input  logic                       din_vld,
  input  logic                       cfg_we,
  input  logic [MAX_LEN-1:0]         cfg_pat,
  input  logic [len_w(MAX_LEN)-1:0]  cfg_len,
  input  logic                       cfg_ovl,
`ifdef SEQ_DET_MASK_EN
  input  logic [MAX_LEN-1:0]         cfg_mask,
`endif
  input  logic                       cnt_clr,
  output logic                       flag,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int            LW        = len_w(MAX_LEN);
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

  typedef struct packed {
    logic [MAX_LEN-1:0] pat;
    logic [LW-1:0]      len;
    logic               ovl;
`ifdef SEQ_DET_MASK_EN
    logic [MAX_LEN-1:0] mask;
`endif
  } cfg_t;

  cfg_t               cfg_q, cfg_d;
  // The oldest window bit is never compared again, so only MAX_LEN-1 bits are kept.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               flag_q, flag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] win;
  logic [LW:0]        fill_p1;
  logic               hit, match;

  assign win     = {hist_q, din};
  assign fill_p1 = {1'b0, fill_q} + (LW+1)'(1);

  seq_window_cmp #(.MAX_LEN(MAX_LEN), .LW(LW)) u_cmp (
    .win_i  (win),
    .pat_i  (cfg_q.pat),
    .len_i  (cfg_q.len),
`ifdef SEQ_DET_MASK_EN
    .mask_i (cfg_q.mask),
`endif
    .hit_o  (hit)
  );

  assign match = din_vld && !cfg_we && (cfg_q.len != '0)
              && (fill_p1 >= {1'b0, cfg_q.len}) && hit;

  always_comb begin
    cfg_d  = cfg_q;
    hist_d = hist_q;
    fill_d = fill_q;
    flag_d = 1'b0;
    cnt_d  = cnt_q;
    if (cfg_we) begin
      cfg_d.pat = cfg_pat;
      cfg_d.len = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
      cfg_d.ovl = cfg_ovl;
`ifdef SEQ_DET_MASK_EN
      cfg_d.mask = cfg_mask;
`endif
      hist_d = '0;
      fill_d = '0;
    end else if (din_vld) begin
      // Non-overlap restarts qualification; stale history is masked by fill.
      if (match && !cfg_q.ovl) begin
        fill_d = '0;
      end else begin
        hist_d = win[MAX_LEN-2:0];
        fill_d = (fill_p1 > {1'b0, MAX_LEN_L}) ? MAX_LEN_L : fill_p1[LW-1:0];
      end
      flag_d = match;
    end
    if (cnt_clr)
      cnt_d = '0;
    else if (match && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q.pat <= RST_PAT;
      cfg_q.len <= LW'(RST_LEN);
      cfg_q.ovl <= RST_OVL;
`ifdef SEQ_DET_MASK_EN
      cfg_q.mask <= '1;
`endif
      hist_q <= '0;
      fill_q <= '0;
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      cfg_q  <= cfg_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign flag      = flag_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_param_seq_detect.sv
// Randomized bench for param_seq_detect against a queue-based reference model.
// Builds with or without SEQ_DET_MASK_EN.
module tb_param_seq_detect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0, din_vld = 1'b0, cfg_we = 1'b0, cfg_ovl = 1'b0, cnt_clr = 1'b0;
  logic [7:0] cfg_pat = '0;
  logic [3:0] cfg_len = '0;
`ifdef SEQ_DET_MASK_EN
  logic [7:0] cfg_mask = '0;
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif
  logic       flag, flag2;
  logic [7:0] match_cnt;
  logic [1:0] cnt2;

  int n_chk = 0, n_err = 0;

  // reference model state
  bit         q[$];
  logic [7:0] m_pat, m_mask;
  int         m_len, m_cnt;
  bit         m_ovl;

  always #5 clk = ~clk;

  param_seq_detect u_dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .cnt_clr(cnt_clr), .flag(flag), .match_cnt(match_cnt)
  );

  param_seq_detect #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .cnt_clr(cnt_clr), .flag(flag2), .match_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got %0d exp %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_pat = 8'b0000_0110; m_len = 4; m_ovl = 1'b1; m_mask = 8'hFF; m_cnt = 0;
  endfunction

  // One clock: drive inputs, advance the model, check both instances after the edge.
  task automatic step(input bit vld, input bit d, input bit we, input bit clr,
                      input logic [7:0] pat, input logic [3:0] len, input bit ovl,
                      input logic [7:0] mask);
    bit exp_flag;
    exp_flag = 1'b0;
    din_vld = vld; din = d; cfg_we = we; cnt_clr = clr;
    cfg_pat = pat; cfg_len = len; cfg_ovl = ovl;
`ifdef SEQ_DET_MASK_EN
    cfg_mask = mask;
`endif
    if (we) begin
      m_pat  = pat;
      m_len  = (int'(len) > 8) ? 8 : int'(len);
      m_ovl  = ovl;
      m_mask = MASK_ON ? mask : 8'hFF;
      q.delete();
    end else if (vld) begin
      q.push_back(d);
      if (q.size() > 8) void'(q.pop_front());
      if (m_len != 0 && q.size() >= m_len) begin
        exp_flag = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (m_mask[m_len-1-k] && (q[q.size()-m_len+k] != m_pat[m_len-1-k]))
            exp_flag = 1'b0;
      end
      if (exp_flag && !m_ovl) q.delete();
    end
    if (clr) m_cnt = 0;
    else if (exp_flag) m_cnt++;
    @(posedge clk); #1;
    chk("flag", flag, exp_flag);
    chk("flag_sat", flag2, exp_flag);
    chk("cnt", match_cnt, sat(m_cnt, 255));
    chk("cnt_sat", cnt2, sat(m_cnt, 3));
  endtask

  task automatic bitin(input bit d);
    step(1'b1, d, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00);
  endtask

  task automatic idle(input bit clr);
    step(1'b0, 1'b0, 1'b0, clr, 8'h00, 4'd0, 1'b0, 8'h00);
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input bit ovl,
                     input logic [7:0] mask);
    step(1'b0, 1'b0, 1'b1, 1'b0, pat, len, ovl, mask);
  endtask

  task automatic stream(input logic [7:0] bits, input int n, output logic [7:0] fv);
    fv = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bitin(bits[i]);
      fv = {fv[6:0], flag};
    end
  endtask

  logic [7:0] fv;
  int         nflag;

  initial begin
    model_reset();
    #12;
    chk("rst_flag", flag, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_cnt_sat", cnt2, 0);
    @(negedge clk); rst = 1'b0;

    // reset defaults: 0110, len 4, overlap
    stream(8'b0110110, 7, fv);
    chk("tp_default_flags", fv, 8'b0001001);
    chk("tp_default_cnt", match_cnt, 2);

    idle(1'b1);
    cfg(8'b0000_0101, 4'd3, 1'b0, 8'hFF);
    stream(8'b10101, 5, fv);
    chk("tp_noovl_flags", fv, 8'b00100);
    chk("tp_noovl_cnt", match_cnt, 1);
    cfg(8'b0000_0101, 4'd3, 1'b1, 8'hFF);
    stream(8'b10101, 5, fv);
    chk("tp_ovl_flags", fv, 8'b00101);

    // idle gaps hold the window
    cfg(8'b0000_0110, 4'd4, 1'b1, 8'hFF);
    bitin(1'b0); bitin(1'b1);
    for (int i = 0; i < 5; i++) idle(1'b0);
    bitin(1'b1);
    bitin(1'b0);
    chk("tp_idle_last", flag, 1);

    // counter saturation and clear priority
    cfg(8'b0000_0001, 4'd1, 1'b1, 8'hFF);
    idle(1'b1);
    for (int i = 0; i < 5; i++) bitin(1'b1);
    chk("tp_sat_cnt2", cnt2, 3);
    chk("tp_sat_cnt8", match_cnt, 5);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 8'h00);
    chk("tp_clr_flag", flag, 1);
    chk("tp_clr_cnt", match_cnt, 0);

    // config write mid-pattern discards history
    cfg(8'b0000_0110, 4'd4, 1'b1, 8'hFF);
    bitin(1'b0); bitin(1'b1); bitin(1'b1);
    cfg(8'b0000_0110, 4'd4, 1'b1, 8'hFF);
    bitin(1'b0);
    chk("tp_cfg_mid", flag, 0);

    // len 0 never matches
    cfg(8'h00, 4'd0, 1'b1, 8'hFF);
    nflag = 0;
    for (int i = 0; i < 20; i++) begin
      bitin(1'($urandom));
      nflag += int'(flag);
    end
    chk("tp_len0", nflag, 0);

    // len 15 clamps to 8
    cfg(8'hA5, 4'd15, 1'b1, 8'hFF);
    stream(8'hA5, 8, fv);
    chk("tp_len15", fv, 8'b0000_0001);

`ifdef SEQ_DET_MASK_EN
    cfg(8'b0110, 4'd4, 1'b1, 8'b1001);
    stream(8'b0000, 4, fv);
    chk("tp_mask_0000", fv[0], 1);
    cfg(8'b0110, 4'd4, 1'b1, 8'b1001);
    stream(8'b0110, 4, fv);
    chk("tp_mask_0110", fv[0], 1);
    cfg(8'b0110, 4'd4, 1'b1, 8'b1001);
    stream(8'b1110, 4, fv);
    chk("tp_mask_1110", fv[0], 0);
`endif

    // reset mid-stream drops the in-flight pulse
    cfg(8'b0110, 4'd4, 1'b1, 8'hFF);
    stream(8'b0110, 4, fv);
    chk("tp_pre_rst_flag", flag, 1);
    rst = 1'b1; #1;
    chk("tp_midrst_flag", flag, 0);
    chk("tp_midrst_cnt", match_cnt, 0);
    model_reset();
    @(negedge clk); rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rl;
      rl = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(4, 1));
      step($urandom_range(99) < 75, 1'($urandom), $urandom_range(99) < 3,
           $urandom_range(99) < 2, 8'($urandom), rl, 1'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/param_seq_detect.md
Name: param_seq_detect

Overview:
- Runtime-programmable serial bit-pattern detector; parametrised successor to the team's fixed-pattern one-hot sequence FSM.
- Pattern, length and overlap mode are loaded through a config write port.
- Input is a valid-qualified serial bit stream; outputs are a one-cycle match flag and a saturating match counter.
- Sits between the deserialiser front end and frame-sync/control logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of match counter.
- RST_PAT, 8'b0000_0110, pattern loaded at reset (low MAX_LEN bits used).
- RST_LEN, 4, pattern length loaded at reset.
- RST_OVL, 1, overlap mode at reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- din  in  1  serial data bit.
- din_vld  in  1  din is valid this cycle.
- cfg_we  in  1  load cfg_pat/cfg_len/cfg_ovl.
- cfg_pat  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length.
- cfg_ovl  in  1  1 = overlapping matches allowed.
- cnt_clr  in  1  synchronous clear of match_cnt.
- flag  out  1  one-cycle pulse per match.
- match_cnt  out  CNT_W  number of matches, saturating.

Behaviour:
- Reset (async, rst=1): hist=0, fill=0, pat=RST_PAT, len=RST_LEN, ovl=RST_OVL, flag=0, match_cnt=0.
- State:
  - hist: MAX_LEN-bit shift register.
  - fill: count of valid bits since last clear, saturating at MAX_LEN.
  - pat/len/ovl: configuration registers.
- Accepted bit (din_vld=1, cfg_we=0):
  - win = {hist[MAX_LEN-2:0], din}; hist <= win.
  - fill <= min(fill+1, MAX_LEN).
- Match condition (accepted bit only): len!=0 AND fill+1 >= len AND win[len-1:0] == pat[len-1:0].
- flag is registered: high on the cycle after the edge that accepted the completing bit (latency 1), for exactly one cycle.
  - flag=0 on any cycle without a match, including din_vld=0 cycles.
- Overlap mode:
  - ovl=1: fill keeps counting after a match, so a suffix of the match may start the next match.
  - ovl=0: on a match, fill <= 0 and hist is unchanged; the next match needs len fresh bits.
- din_vld=0: hist and fill hold; flag <= 0.
- cfg_we=1:
  - pat/len/ovl load; hist <= 0; fill <= 0; flag <= 0.
  - din on the same cycle is ignored, even if din_vld=1.
  - match_cnt is not affected.
- Length boundaries:
  - cfg_len=0: detector disabled, never matches.
  - cfg_len > MAX_LEN: clamped to MAX_LEN on load.
  - cfg_len=1: every accepted bit equal to pat[0] matches.
- match_cnt:
  - +1 per match; saturates at all-ones with no wrap.
  - cnt_clr has priority: a match in the same cycle is not counted (count=0), but flag still pulses.
- Reset mid-stream: everything returns to reset values immediately; a flag pulse in flight is dropped.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- Defined:
  - Extra port cfg_mask (in, MAX_LEN), loaded with cfg_we; reset value all-ones.
  - Bits with mask=0 are don't-care in the compare: match when (win ^ pat) & mask is 0 over [len-1:0].
  - The fill/length qualification is unchanged.
- Undefined: no cfg_mask port; exact compare as above.

Decomposition:
- Package seq_detect_pkg:
  - len_w(MAX_LEN) function returning $clog2(MAX_LEN+1).
  - Default reset pattern/length constants.
  - Typedef for the config bundle {pat, len, ovl[, mask]}.
- Sub-module seq_window_cmp: combinational len-limited (optionally masked) compare of win against pat.
- Registers, fill counter and match_cnt live in the top module.

Test Plan:
- Reset defaults (pat 0110, len 4, ovl 1), stream 0,1,1,0,1,1,0 all valid -> flag pulses after 4th and 7th bits; match_cnt=2.
- cfg pat=8'b0000_0101, len=3, ovl=0, stream 1,0,1,0,1 -> single flag after 3rd bit; match_cnt=1. Same stream with ovl=1 -> flags after 3rd and 5th bits.
- Stream 0,1 then din_vld=0 for 5 cycles then 1,0 -> flag only after the final 0; no flag in idle cycles.
- CNT_W=2, 5 matches -> match_cnt sticks at 3. cnt_clr coincident with a match -> match_cnt=0 while flag=1.
- cfg_we mid-pattern (after 0,1,1), then 0 -> no flag. cfg_len=0 -> no flag on any stream. cfg_len=15 with MAX_LEN=8 -> behaves as len 8.
- SEQ_DET_MASK_EN: pat 0110, mask 1001, len 4 -> both 0000 and 0110 streams flag; 1110 does not.
